// File: rtl/feedback_delay_mc.sv
`default_nettype none
// ==========================================================================
// feedback_delay_mc : multichannel feedback delay line over one shared RAM
// Rev 1.0
// ==========================================================================
module feedback_delay_mc #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 12,
  parameter int NUM_CH = 2,
  parameter int COEF_W = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     bypass,
  input  logic [ADDR_W-1:0]        delay,
  input  logic [COEF_W-1:0]        fb_gain,
  input  logic [COEF_W-1:0]        wet_gain,
  input  logic [COEF_W-1:0]        dry_gain,
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic [NUM_CH*DATA_W-1:0] din,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic [NUM_CH*DATA_W-1:0] dout
);
  localparam int c_ch_w  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int c_aw    = c_ch_w + ADDR_W;
  localparam int c_depth = NUM_CH << ADDR_W;
  localparam int c_pw    = DATA_W + COEF_W + 1;
  localparam int c_sh    = COEF_W - 1;

  localparam logic [c_aw-1:0]          c_clr_last = c_aw'(c_depth - 1);
  localparam logic [c_ch_w-1:0]        c_ch_last  = c_ch_w'(NUM_CH - 1);
  localparam logic signed [c_pw-1:0]   c_max = {{(c_pw-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [c_pw-1:0]   c_min = {{(c_pw-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

  localparam logic [2:0] c_st_clear = 3'd0;
  localparam logic [2:0] c_st_idle  = 3'd1;
  localparam logic [2:0] c_st_rd    = 3'd2;
  localparam logic [2:0] c_st_mac   = 3'd3;
  localparam logic [2:0] c_st_wr    = 3'd4;
  localparam logic [2:0] c_st_out   = 3'd5;

  logic [2:0]                r_state, w_next;
  logic [c_aw-1:0]           r_clr_addr;
  logic [ADDR_W-1:0]         r_wr_ptr, r_delay, w_rd_ptr;
  logic [c_ch_w-1:0]         r_ch;
  logic                      w_last_ch;
  logic [NUM_CH*DATA_W-1:0]  r_din, r_dout;
  logic signed [COEF_W-1:0]  r_fb_gain, r_wet_gain, r_dry_gain;
  logic                      r_bypass;
  logic [DATA_W-1:0]         r_mem [c_depth];
  logic signed [DATA_W-1:0]  r_rdata, w_din_ch;
  logic signed [c_pw-1:0]    r_fb, r_o;
  logic signed [c_pw-1:0]    w_y_x, w_din_x, w_fbg_x, w_wetg_x, w_dryg_x;
  logic signed [c_pw-1:0]    w_fb_new, w_o_new, w_wr_sum;
  logic [DATA_W-1:0]         w_wr_sat, w_o_sat, w_ram_wdata;
  logic                      w_ram_we, w_ram_re;
  logic [c_aw-1:0]           w_ram_addr;

  function automatic logic [DATA_W-1:0] f_sat(input logic signed [c_pw-1:0] v);
    if (v > c_max)      return c_max[DATA_W-1:0];
    else if (v < c_min) return c_min[DATA_W-1:0];
    else                return v[DATA_W-1:0];
  endfunction

  assign w_last_ch = (r_ch == c_ch_last);
  assign w_rd_ptr  = r_wr_ptr - r_delay;
  assign w_din_ch  = r_din[r_ch*DATA_W +: DATA_W];

  assign w_y_x    = {{(c_pw-DATA_W){r_rdata[DATA_W-1]}}, r_rdata};
  assign w_din_x  = {{(c_pw-DATA_W){w_din_ch[DATA_W-1]}}, w_din_ch};
  assign w_fbg_x  = {{(c_pw-COEF_W){r_fb_gain[COEF_W-1]}}, r_fb_gain};
  assign w_wetg_x = {{(c_pw-COEF_W){r_wet_gain[COEF_W-1]}}, r_wet_gain};
  assign w_dryg_x = {{(c_pw-COEF_W){r_dry_gain[COEF_W-1]}}, r_dry_gain};

  // Full-precision products; arithmetic shift rounds toward -inf.
  assign w_fb_new = (w_y_x * w_fbg_x) >>> c_sh;
  assign w_o_new  = (w_din_x * w_dryg_x + w_y_x * w_wetg_x) >>> c_sh;
  assign w_wr_sum = w_din_x + r_fb;
  assign w_wr_sat = f_sat(w_wr_sum);
  assign w_o_sat  = f_sat(r_o);

  assign dout = r_dout;

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= c_st_clear;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      c_st_clear: if (r_clr_addr == c_clr_last) w_next = c_st_idle;
      c_st_idle:  if (s_valid) w_next = c_st_rd;
      c_st_rd:    w_next = c_st_mac;
      c_st_mac:   w_next = c_st_wr;
      c_st_wr:    w_next = w_last_ch ? c_st_out : c_st_rd;
      c_st_out:   if (m_ready) w_next = c_st_idle;
      default:    w_next = c_st_clear;
    endcase
  end

  always_comb begin
    s_ready     = 1'b0;
    m_valid     = 1'b0;
    w_ram_we    = 1'b0;
    w_ram_re    = 1'b0;
    w_ram_addr  = r_clr_addr;
    w_ram_wdata = '0;
    case (r_state)
      c_st_clear: w_ram_we = 1'b1;
      c_st_idle:  s_ready = 1'b1;
      c_st_rd: begin
        w_ram_re   = 1'b1;
        w_ram_addr = {r_ch, w_rd_ptr};
      end
      c_st_wr: begin
        w_ram_we    = 1'b1;
        w_ram_addr  = {r_ch, r_wr_ptr};
        w_ram_wdata = w_wr_sat;
      end
      c_st_out:   m_valid = 1'b1;
      default:    ;
    endcase
  end

  // Single-port buffer: one read or one write per cycle.
  always_ff @(posedge clk) begin
    if (w_ram_we && rst_n) r_mem[w_ram_addr] <= w_ram_wdata;
    if (w_ram_re)          r_rdata <= r_mem[w_ram_addr];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_clr_addr <= '0;
      r_wr_ptr   <= '0;
      r_ch       <= '0;
      r_dout     <= '0;
      r_din      <= '0;
      r_delay    <= '0;
      r_fb_gain  <= '0;
      r_wet_gain <= '0;
      r_dry_gain <= '0;
      r_bypass   <= 1'b0;
      r_fb       <= '0;
      r_o        <= '0;
    end else begin
      case (r_state)
        c_st_clear: r_clr_addr <= r_clr_addr + 1'b1;
        c_st_idle: begin
          if (s_valid) begin
            r_din      <= din;
            r_delay    <= (delay == '0) ? ADDR_W'(1) : delay;
            r_fb_gain  <= fb_gain;
            r_wet_gain <= wet_gain;
            r_dry_gain <= dry_gain;
            r_bypass   <= bypass;
            r_ch       <= '0;
          end
        end
        c_st_mac: begin
          r_fb <= w_fb_new;
          r_o  <= w_o_new;
        end
        c_st_wr: begin
          r_dout[r_ch*DATA_W +: DATA_W] <= r_bypass ? w_din_ch : w_o_sat;
          if (w_last_ch) r_wr_ptr <= r_wr_ptr + 1'b1;
          else           r_ch     <= r_ch + 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_feedback_delay_mc.sv
`default_nettype none
// ==========================================================================
// tb_feedback_delay_mc : directed self-checking bench for feedback_delay_mc
// Rev 1.0
// ==========================================================================
module tb_feedback_delay_mc;
  localparam int DATA_W = 16;
  localparam int ADDR_W = 4;
  localparam int NUM_CH = 2;
  localparam int COEF_W = 16;
  localparam int FW     = NUM_CH * DATA_W;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              bypass;
  logic [ADDR_W-1:0] delay;
  logic [COEF_W-1:0] fb_gain, wet_gain, dry_gain;
  logic              s_valid, s_ready, m_valid, m_ready;
  logic [FW-1:0]     din, dout;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int t_acc    = 0;
  int t_prev   = 0;
  int t_hs     = 0;

  feedback_delay_mc #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_CH(NUM_CH), .COEF_W(COEF_W)
  ) u_dut (
    .clk(clk), .rst_n(rst_n), .bypass(bypass), .delay(delay),
    .fb_gain(fb_gain), .wet_gain(wet_gain), .dry_gain(dry_gain),
    .s_valid(s_valid), .s_ready(s_ready), .din(din),
    .m_valid(m_valid), .m_ready(m_ready), .dout(dout)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic cfg(input logic [ADDR_W-1:0] d, input logic [15:0] fb, input logic [15:0] wet,
                     input logic [15:0] dry, input logic byp);
    delay = d; fb_gain = fb; wet_gain = wet; dry_gain = dry; bypass = byp;
  endtask

  task automatic do_reset;
    int n;
    rst_n = 1'b0; s_valid = 1'b0; m_ready = 1'b0;
    tick; tick;
    chk("rst_s_ready", s_ready, 0);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_dout", dout, 0);
    rst_n = 1'b1;
    n = 0;
    while (!s_ready && n < 200) begin tick; n++; end
    chk("clear_cycles", n, 32);
  endtask

  // One frame: accept, wait for output, optionally stall m_ready for `hold` cycles.
  task automatic frame(input string tag, input logic [FW-1:0] d, input logic [FW-1:0] exp, input int hold);
    int n;
    din = d; s_valid = 1'b1; m_ready = (hold == 0);
    n = 0;
    while (!s_ready && n < 100) begin tick; n++; end
    chk({tag, "_ready"}, s_ready, 1);
    tick;
    t_prev = t_acc; t_acc = cyc;
    s_valid = 1'b0; din = '0;
    n = 0;
    while (!m_valid && n < 100) begin tick; n++; end
    chk({tag, "_valid"}, m_valid, 1);
    chk({tag, "_dout"}, dout, exp);
    for (int i = 0; i < hold; i++) begin
      tick;
      chk({tag, "_hold_valid"}, m_valid, 1);
      chk({tag, "_hold_dout"}, dout, exp);
      chk({tag, "_hold_sready"}, s_ready, 0);
    end
    m_ready = 1'b1;
    tick;
    t_hs = cyc;
    m_ready = 1'b0;
    chk({tag, "_hs_drop"}, m_valid, 0);
    chk({tag, "_hs_idle"}, s_ready, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail + 1);
    $fatal(1);
  end

  initial begin
    logic [15:0] fb_exp [8];
    logic [15:0] h0 [40];
    logic [15:0] h1 [40];
    logic [FW-1:0] e;
    int h;

    rst_n = 1'b0; bypass = 1'b0; delay = '0; fb_gain = '0; wet_gain = '0; dry_gain = '0;
    s_valid = 1'b0; m_ready = 1'b0; din = '0;

    // Cleared buffer reads back zero through the wet path
    do_reset();
    cfg(3, 16'h0, 16'h7FFF, 16'h0, 1'b0);
    for (int i = 0; i < 16; i++) frame($sformatf("clear_f%0d", i), '0, '0, 0);

    // Impulse through a 3-frame delay
    do_reset();
    cfg(3, 16'h0, 16'h7FFF, 16'h0, 1'b0);
    for (int i = 0; i < 6; i++)
      frame($sformatf("imp_f%0d", i), (i == 0) ? 32'h0000_4000 : 32'h0,
            (i == 3) ? 32'h0000_3FFF : 32'h0, 0);

    // Impulse with half-gain feedback, delay 2
    do_reset();
    cfg(2, 16'h4000, 16'h7FFF, 16'h0, 1'b0);
    fb_exp = '{16'h0, 16'h0, 16'h3FFF, 16'h0, 16'h1FFF, 16'h0, 16'h0FFF, 16'h0};
    for (int i = 0; i < 8; i++)
      frame($sformatf("fb_f%0d", i), (i == 0) ? 32'h0000_4000 : 32'h0, {16'h0, fb_exp[i]}, 0);

    // Saturation, plus back-to-back throughput
    do_reset();
    cfg(1, 16'h7FFF, 16'h7FFF, 16'h7FFF, 1'b0);
    for (int i = 0; i < 6; i++) begin
      frame($sformatf("sat_f%0d", i), 32'h7000_7000, (i == 0) ? 32'h6FFF_6FFF : 32'h7FFF_7FFF, 0);
      if (i > 0) chk("throughput", t_acc - t_prev, 8);
    end

    // Delay 0 is treated as delay 1
    do_reset();
    cfg(0, 16'h0, 16'h7FFF, 16'h0, 1'b0);
    for (int i = 0; i < 3; i++)
      frame($sformatf("d0_f%0d", i), (i == 0) ? 32'h0000_4000 : 32'h0,
            (i == 1) ? 32'h0000_3FFF : 32'h0, 0);

    // Max delay across write-pointer wrap; positive ch0 loses 1 LSB, negative ch1 exact
    do_reset();
    cfg(15, 16'h0, 16'h7FFF, 16'h0, 1'b0);
    for (int n = 0; n < 40; n++) begin
      h0[n] = 16'((n + 1) * 256);
      h1[n] = 16'(-(n + 1) * 128);
      e = (n < 15) ? '0 : {h1[n-15], h0[n-15] - 16'd1};
      frame($sformatf("wrap_f%0d", n), {h1[n], h0[n]}, e, 0);
    end

    // Backpressure on a dry-only frame, then bypass, then bypass data re-read from buffer
    do_reset();
    cfg(1, 16'h0, 16'h0, 16'h4000, 1'b0);
    frame("bp", 32'hF000_1234, 32'hF800_091A, 5);
    h = t_hs;
    cfg(1, 16'h0, 16'h7FFF, 16'h0, 1'b1);
    frame("bypass", 32'h1234_5678, 32'h1234_5678, 0);
    chk("hs_to_accept", t_acc - h, 1);
    cfg(1, 16'h0, 16'h7FFF, 16'h0, 1'b0);
    frame("post_bypass", 32'h0, 32'h1233_5677, 0);

    // Reset during MAC discards the frame and re-clears the buffer
    do_reset();
    cfg(1, 16'h0, 16'h0, 16'h7FFF, 1'b0);
    for (int i = 0; i < 4; i++) frame($sformatf("pre_f%0d", i), 32'h1000_1000, 32'h0FFF_0FFF, 0);
    din = 32'h1000_1000; s_valid = 1'b1; m_ready = 1'b1;
    chk("mid_accept_ready", s_ready, 1);
    tick;
    s_valid = 1'b0;
    tick;
    rst_n = 1'b0;
    tick;
    chk("mid_m_valid", m_valid, 0);
    chk("mid_s_ready", s_ready, 0);
    chk("mid_dout", dout, 0);
    do_reset();
    cfg(15, 16'h0, 16'h7FFF, 16'h0, 1'b0);
    for (int i = 0; i < 3; i++) frame($sformatf("post_rst_f%0d", i), '0, '0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
